// File: rtl/fp_mul_seq.sv
// -----------------------------------------------------------------------------
// fp_mul_seq
//   Sequential IEEE-754-style floating-point multiplier. Significands are
//   multiplied by iterative shift-add, one multiplier bit per cycle. The result
//   is rounded to nearest-even. Subnormal inputs and subnormal results are
//   flushed to zero. NaN, infinity and zero operands follow the usual IEEE rules.
//   Every operand class takes the same fixed latency: out_valid rises
//   MAN_W+2 edges after the accepting edge.
//
//   Optional feature macro: FP_MUL_SEQ_FLAGS_EN
//     When defined, out_flags[3:0] = {invalid, overflow, underflow, inexact}
//     is added. The flags are registered together with the result.
//
// Ports
//   clock                       rising-edge clock
//   reset                       synchronous, active-low
//   in_valid / in_ready         operand handshake
//   in_a_* / in_b_*             operand sign, biased exponent, mantissa
//   out_valid / out_ready       result handshake
//   out_sign/exponent/mantissa  result fields
//   out_flags                   exception flags (FP_MUL_SEQ_FLAGS_EN only)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready=1
// MUL   | shift-add iterations 0..MAN_W on the significands
// NORM  | normalise, round, apply specials, load result registers
// DONE  | result presented; held until out_ready
// -----------------------------------------------------------------------------
module fp_mul_seq #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_a_sign,
   input  logic [EXP_W-1:0] in_a_exponent,
   input  logic [MAN_W-1:0] in_a_mantissa,
   input  logic             in_b_sign,
   input  logic [EXP_W-1:0] in_b_exponent,
   input  logic [MAN_W-1:0] in_b_mantissa,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exponent,
   output logic [MAN_W-1:0] out_mantissa
`ifdef FP_MUL_SEQ_FLAGS_EN
   ,
   output logic [3:0]       out_flags
`endif
);

   localparam int SIG_W  = MAN_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int CNT_W  = $clog2(SIG_W + 1);
   localparam int EW2    = EXP_W + 2;
   localparam int BIAS   = 2**(EXP_W-1) - 1;
   localparam int EMAX   = 2**EXP_W - 1;

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_e;

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                sign_q;
   logic                nan_q, inf_q, zero_q;
   logic [EXP_W-1:0]    ea_q, eb_q;
   logic [SIG_W-1:0]    mcand_q, mplier_q;
   logic [PROD_W-1:0]   prod_q, prod_d;
   logic                res_sign_q;
   logic [EXP_W-1:0]    res_exp_q;
   logic [MAN_W-1:0]    res_man_q;

   // operand classification (exp==0 covers zero and flushed subnormals)
   logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   assign a_zero = (in_a_exponent == '0);
   assign b_zero = (in_b_exponent == '0);
   assign a_inf  = (&in_a_exponent) && (in_a_mantissa == '0);
   assign b_inf  = (&in_b_exponent) && (in_b_mantissa == '0);
   assign a_nan  = (&in_a_exponent) && (in_a_mantissa != '0);
   assign b_nan  = (&in_b_exponent) && (in_b_mantissa != '0);

   // one shift-add step: add multiplicand << cnt when multiplier bit cnt is set
   always_comb begin
      prod_d = prod_q;
      if (mplier_q[cnt_q])
         prod_d = prod_q + (PROD_W'(mcand_q) << cnt_q);
   end

   // normalise and round
   logic                  msb;
   logic [PROD_W-1:0]     norm;
   logic [MAN_W-1:0]      man_raw;
   logic                  g_bit, s_bit, rnd_up;
   logic [MAN_W:0]        man_rnd;
   logic signed [EW2-1:0] e_unb, e_rnd;
   logic                  ovf, unf, finite;
   logic                  nxt_sign;
   logic [EXP_W-1:0]      nxt_exp;
   logic [MAN_W-1:0]      nxt_man;

   always_comb begin
      msb     = prod_q[PROD_W-1];
      norm    = msb ? prod_q : (prod_q << 1);
      man_raw = norm[PROD_W-2 -: MAN_W];
      g_bit   = norm[PROD_W-2-MAN_W];
      s_bit   = |norm[PROD_W-3-MAN_W:0];
      rnd_up  = g_bit & (s_bit | man_raw[0]);
      man_rnd = {1'b0, man_raw} + {{MAN_W{1'b0}}, rnd_up};
      e_unb   = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q})
                - $signed(EW2'(BIAS)) + $signed({{(EW2-1){1'b0}}, msb});
      // a rounding carry leaves the mantissa field at zero and bumps the exponent
      e_rnd   = e_unb + $signed({{(EW2-1){1'b0}}, man_rnd[MAN_W]});
      ovf     = (e_rnd >= $signed(EW2'(EMAX)));
      unf     = (e_rnd <= $signed(EW2'(0)));
      finite  = !(nan_q || inf_q || zero_q);

      nxt_sign = sign_q;
      nxt_exp  = e_rnd[EXP_W-1:0];
      nxt_man  = man_rnd[MAN_W-1:0];
      if (nan_q) begin
         nxt_sign = 1'b0;
         nxt_exp  = '1;
         nxt_man  = {1'b1, {(MAN_W-1){1'b0}}};
      end else if (inf_q || (finite && ovf)) begin
         nxt_exp  = '1;
         nxt_man  = '0;
      end else if (zero_q || unf) begin
         nxt_exp  = '0;
         nxt_man  = '0;
      end
   end

`ifdef FP_MUL_SEQ_FLAGS_EN
   logic [3:0] flags_q, nxt_flags;
   assign nxt_flags = {nan_q,
                       finite & ovf,
                       finite & unf,
                       finite & (g_bit | s_bit | ovf | unf)};
   assign out_flags = flags_q;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         nan_q      <= 1'b0;
         inf_q      <= 1'b0;
         zero_q     <= 1'b0;
         ea_q       <= '0;
         eb_q       <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         prod_q     <= '0;
         res_sign_q <= 1'b0;
         res_exp_q  <= '0;
         res_man_q  <= '0;
`ifdef FP_MUL_SEQ_FLAGS_EN
         flags_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sign_q   <= in_a_sign ^ in_b_sign;
                  nan_q    <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
                  inf_q    <= a_inf | b_inf;
                  zero_q   <= a_zero | b_zero;
                  ea_q     <= in_a_exponent;
                  eb_q     <= in_b_exponent;
                  mcand_q  <= {1'b1, in_a_mantissa};
                  mplier_q <= {1'b1, in_b_mantissa};
                  prod_q   <= '0;
                  cnt_q    <= '0;
                  state_q  <= MUL;
               end
            end
            MUL: begin
               prod_q <= prod_d;
               if (cnt_q == CNT_W'(MAN_W)) begin
                  state_q <= NORM;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            NORM: begin
               res_sign_q <= nxt_sign;
               res_exp_q  <= nxt_exp;
               res_man_q  <= nxt_man;
`ifdef FP_MUL_SEQ_FLAGS_EN
               flags_q    <= nxt_flags;
`endif
               state_q    <= DONE;
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready     = (state_q == IDLE);
   assign out_valid    = (state_q == DONE);
   assign out_sign     = res_sign_q;
   assign out_exponent = res_exp_q;
   assign out_mantissa = res_man_q;

endmodule
